// File: rtl/user_traffic_gen.sv
// ---------------------------------------------------------------------------
// user_traffic_gen
//
// Purpose:
//   Generates user-side write commands with data beats, and read commands,
//   for the user command/data FIFOs of an AXI4 full master bridge. It
//   supports runtime packet length, write backpressure, four data patterns
//   and a wrapping address window.
//
// Optional feature (macro USER_TRAFFIC_RD_CHECK_EN):
//   When defined, adds a read-data checker. It regenerates the pattern of
//   the most recent accepted write for each read packet and counts mismatches.
//   When undefined, those ports and that logic are absent.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   wr_trig           one-cycle write request (honoured only in IDLE)
//   rd_trig           one-cycle read request (honoured while user_cmd_ren low)
//   pkt_len[11:0]     packet length in beats, sampled on an accepted trigger
//   pat_mode[1:0]     data pattern, sampled on an accepted wr_trig
//   user_cmd_wen      write command strobe
//   user_wr_cmd       {len[11:0], addr}, zero when user_cmd_wen is low
//   user_wr_en        write data valid
//   user_wr_ready     downstream accepts the beat
//   user_wr_data      write beat
//   user_wr_last      final beat of the packet, qualified by user_wr_en
//   wr_busy           write FSM not in IDLE
//   wr_done           one-cycle pulse when a packet completes
//   user_cmd_ren      read command strobe
//   user_rd_cmd       {len[11:0], addr}, zero when user_cmd_ren is low
//   (checker only)    user_rd_valid, user_rd_data in; rd_err_cnt, rd_check_done out
//
// Handshake: a write beat transfers in every cycle where user_wr_en and
// user_wr_ready are both high. While user_wr_en is high and user_wr_ready
// is low, user_wr_data and user_wr_last stay stable. user_wr_en is never
// withdrawn before the beat transfers.
// ---------------------------------------------------------------------------
module user_traffic_gen #(
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter int                        USER_DATA_WIDTH = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SPAN       = 32'h0010_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_trig,
  input  logic                           rd_trig,
  input  logic [11:0]                    pkt_len,
  input  logic [1:0]                     pat_mode,
  output logic                           user_cmd_wen,
  output logic [AXI_ADDR_WIDTH+11:0]     user_wr_cmd,
  output logic                           user_wr_en,
  input  logic                           user_wr_ready,
  output logic [USER_DATA_WIDTH-1:0]     user_wr_data,
  output logic                           user_wr_last,
  output logic                           wr_busy,
  output logic                           wr_done,
  output logic                           user_cmd_ren,
  output logic [AXI_ADDR_WIDTH+11:0]     user_rd_cmd
`ifdef USER_TRAFFIC_RD_CHECK_EN
  ,
  input  logic                           user_rd_valid,
  input  logic [USER_DATA_WIDTH-1:0]     user_rd_data,
  output logic [15:0]                    rd_err_cnt,
  output logic                           rd_check_done
`endif
);

  localparam int DW = USER_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  // Address arithmetic is carried out wide enough that adding a full
  // 4095-beat step never overflows before the wrap comparison.
  localparam int CW = AW + 14;

  localparam logic [CW-1:0] BPB        = CW'(DW / 8);
  // Highest start address whose worst-case next packet still fits.
  localparam logic [CW-1:0] WRAP_LIMIT = CW'(BASE_ADDR) + CW'(ADDR_SPAN)
                                         - CW'(1) - (CW'(4095) * BPB);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WCMD  = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_WEND  = 2'd3;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [11:0]   len);
    logic [CW-1:0] sum;
    sum = CW'(a) + (CW'(len) * BPB);
    if (sum > WRAP_LIMIT) next_addr = BASE_ADDR;
    else                  next_addr = sum[AW-1:0];
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in shift-right form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Replicate (DW > 16) or truncate (DW < 16) the 16-bit LFSR value.
  function automatic logic [DW-1:0] expand16(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[i % 16];
    expand16 = r;
  endfunction

  function automatic logic [DW-1:0] walk1(input logic [11:0] k);
    logic [11:0] s;
    s = k % 12'(DW);
    walk1 = {{(DW-1){1'b0}}, 1'b1} << s;
  endfunction

  function automatic logic [DW-1:0] pat_value(input logic [1:0]    mode,
                                              input logic [11:0]   k,
                                              input logic [DW-1:0] free,
                                              input logic [15:0]   lfsr);
    logic [DW-1:0] r;
    r = '0;
    case (mode)
      2'd0:    r = DW'(k);
      2'd1:    r = free;
      2'd2:    r = expand16(lfsr);
      default: r = walk1(k);
    endcase
    pat_value = r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [11:0]   r_len;
  logic [1:0]    r_mode;
  logic [11:0]   r_beat;
  logic [DW-1:0] r_free;
  logic [15:0]   r_lfsr;
  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_raddr;
  logic          r_rd_ren;
  logic [11:0]   r_rd_len;

  logic          w_in_wdata;
  logic          w_beat_xfer;
  logic          w_is_last;

  assign w_in_wdata  = (r_state == S_WDATA);
  assign w_beat_xfer = w_in_wdata & user_wr_ready;
  assign w_is_last   = (r_beat == (r_len - 12'd1));

  // -------------------------------------------------------------------------
  // Write FSM and read command register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_mode   <= '0;
      r_beat   <= '0;
      r_free   <= '0;
      r_lfsr   <= LFSR_SEED;
      r_waddr  <= BASE_ADDR;
      r_raddr  <= BASE_ADDR;
      r_rd_ren <= 1'b0;
      r_rd_len <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A zero-length request would never produce a last beat, so it
          // is simply ignored.
          if (wr_trig && (pkt_len != 12'd0)) begin
            r_len   <= pkt_len;
            r_mode  <= pat_mode;
            r_state <= S_WCMD;
          end
        end
        S_WCMD: begin
          r_beat  <= '0;
          r_lfsr  <= LFSR_SEED;
          r_state <= S_WDATA;
        end
        S_WDATA: begin
          if (w_beat_xfer) begin
            r_beat <= r_beat + 12'd1;
            r_lfsr <= lfsr_step(r_lfsr);
            // The free-running counter advances on every transferred beat,
            // whatever pattern is selected, so mode 1 continues from the
            // total beat count since reset.
            r_free <= r_free + DW'(1);
            if (w_is_last) r_state <= S_WEND;
          end
        end
        S_WEND: begin
          r_waddr <= next_addr(r_waddr, r_len);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // The read command is a one-cycle strobe. The address advances on the
      // edge that ends the strobe cycle.
      if (r_rd_ren) begin
        r_rd_ren <= 1'b0;
        r_raddr  <= next_addr(r_raddr, r_rd_len);
      end else if (rd_trig) begin
        r_rd_ren <= 1'b1;
        r_rd_len <= pkt_len;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign user_cmd_wen = (r_state == S_WCMD);
  assign user_wr_cmd  = user_cmd_wen ? {r_len, r_waddr} : '0;
  assign user_wr_en   = w_in_wdata;
  assign user_wr_last = w_in_wdata & w_is_last;
  assign user_wr_data = w_in_wdata ? pat_value(r_mode, r_beat, r_free, r_lfsr) : '0;
  assign wr_busy      = (r_state != S_IDLE);
  assign wr_done      = (r_state == S_WEND);
  assign user_cmd_ren = r_rd_ren;
  assign user_rd_cmd  = r_rd_ren ? {r_rd_len, r_raddr} : '0;

`ifdef USER_TRAFFIC_RD_CHECK_EN
  // -------------------------------------------------------------------------
  // Read-data checker: restarts on every read command. Mode 1 is checked as
  // a per-packet count, because the free-running write value is unknown
  // at read time.
  // -------------------------------------------------------------------------
  logic [11:0]   r_chk_idx;
  logic [11:0]   r_chk_len;
  logic [15:0]   r_chk_lfsr;
  logic [15:0]   r_err_cnt;
  logic          r_chk_done;
  logic [1:0]    w_chk_mode;
  logic [DW-1:0] w_chk_exp;

  assign w_chk_mode = (r_mode == 2'd1) ? 2'd0 : r_mode;
  assign w_chk_exp  = pat_value(w_chk_mode, r_chk_idx, '0, r_chk_lfsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_idx  <= '0;
      r_chk_len  <= '0;
      r_chk_lfsr <= LFSR_SEED;
      r_err_cnt  <= '0;
      r_chk_done <= 1'b0;
    end else begin
      r_chk_done <= 1'b0;
      if (r_rd_ren) begin
        r_chk_idx  <= '0;
        r_chk_len  <= r_rd_len;
        r_chk_lfsr <= LFSR_SEED;
      end else if (user_rd_valid) begin
        if ((user_rd_data != w_chk_exp) && (r_err_cnt != 16'hFFFF))
          r_err_cnt <= r_err_cnt + 16'd1;
        r_chk_idx  <= r_chk_idx + 12'd1;
        r_chk_lfsr <= lfsr_step(r_chk_lfsr);
        if (r_chk_idx == (r_chk_len - 12'd1)) r_chk_done <= 1'b1;
      end
    end
  end

  assign rd_err_cnt    = r_err_cnt;
  assign rd_check_done = r_chk_done;
`endif

endmodule

// File: tb/tb_user_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_user_traffic_gen
//
// Self-checking bench for user_traffic_gen. A behavioural model computes
// expected commands, data beats and addresses from packet parameters; a
// negedge monitor compares DUT activity against the expected queues.
// ---------------------------------------------------------------------------
module tb_user_traffic_gen;

  localparam int          AW   = 32;
  localparam int          DW   = 16;
  localparam int          BPB  = DW / 8;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wr_trig;
  logic          rd_trig;
  logic [11:0]   pkt_len;
  logic [1:0]    pat_mode;
  logic          user_cmd_wen;
  logic [AW+11:0] user_wr_cmd;
  logic          user_wr_en;
  logic          user_wr_ready;
  logic [DW-1:0] user_wr_data;
  logic          user_wr_last;
  logic          wr_busy;
  logic          wr_done;
  logic          user_cmd_ren;
  logic [AW+11:0] user_rd_cmd;
`ifdef USER_TRAFFIC_RD_CHECK_EN
  logic          user_rd_valid;
  logic [DW-1:0] user_rd_data;
  logic [15:0]   rd_err_cnt;
  logic          rd_check_done;
`endif

  user_traffic_gen #(
    .AXI_ADDR_WIDTH (AW),
    .USER_DATA_WIDTH(DW),
    .BASE_ADDR      (BASE),
    .ADDR_SPAN      (SPAN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_trig      (wr_trig),
    .rd_trig      (rd_trig),
    .pkt_len      (pkt_len),
    .pat_mode     (pat_mode),
    .user_cmd_wen (user_cmd_wen),
    .user_wr_cmd  (user_wr_cmd),
    .user_wr_en   (user_wr_en),
    .user_wr_ready(user_wr_ready),
    .user_wr_data (user_wr_data),
    .user_wr_last (user_wr_last),
    .wr_busy      (wr_busy),
    .wr_done      (wr_done),
    .user_cmd_ren (user_cmd_ren),
    .user_rd_cmd  (user_rd_cmd)
`ifdef USER_TRAFFIC_RD_CHECK_EN
    ,
    .user_rd_valid(user_rd_valid),
    .user_rd_data (user_rd_data),
    .rd_err_cnt   (rd_err_cnt),
    .rd_check_done(rd_check_done)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW+11:0] exp_wcmd_q[$];
  logic [AW+11:0] exp_rcmd_q[$];
  logic [DW-1:0]  exp_q[$];
  logic           exp_last_q[$];
  longint         waddr_m;
  longint         raddr_m;
  logic [DW-1:0]  free_m;

  function automatic longint adv(input longint a, input int len);
    longint limit;
    longint nxt;
    limit = longint'(BASE) + longint'(SPAN) - 1 - 4095 * BPB;
    nxt   = a + longint'(len) * BPB;
    return (nxt > limit) ? longint'(BASE) : nxt;
  endfunction

  task automatic push_write(input int len, input logic [1:0] mode);
    logic [15:0]   lf;
    logic [DW-1:0] v;
    logic [31:0]   a32;
    a32 = 32'(waddr_m);
    exp_wcmd_q.push_back({12'(len), a32});
    lf = 16'hACE1;
    for (int k = 0; k < len; k++) begin
      v = '0;
      case (mode)
        2'd0: v = DW'(k);
        2'd1: v = free_m + DW'(k);
        2'd2: for (int b = 0; b < DW; b++) v[b] = lf[b % 16];
        default: v[k % DW] = 1'b1;
      endcase
      exp_q.push_back(v);
      exp_last_q.push_back(k == len - 1);
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    free_m  = free_m + DW'(len);
    waddr_m = adv(waddr_m, len);
  endtask

  task automatic push_read(input int len);
    logic [31:0] a32;
    a32 = 32'(raddr_m);
    exp_rcmd_q.push_back({12'(len), a32});
    raddr_m = adv(raddr_m, len);
  endtask

  // ---------------- monitor / scoreboard ----------------
`ifdef USER_TRAFFIC_RD_CHECK_EN
  int chk_done_seen = 0;
`endif

  always @(negedge clk) begin
    if (!reset) begin
      if (user_cmd_wen) begin
        if (exp_wcmd_q.size() == 0) check_val("wcmd_unexpected", 64'(1), 64'(0));
        else begin
          logic [AW+11:0] e;
          longint a, l;
          e = exp_wcmd_q.pop_front();
          check_val("wcmd", 64'(user_wr_cmd), 64'(e));
          a = longint'(user_wr_cmd[AW-1:0]);
          l = longint'(user_wr_cmd[AW+11:AW]);
          check_val("wcmd_window",
                    64'(a + l * BPB - 1 <= longint'(BASE) + longint'(SPAN) - 1), 64'(1));
        end
      end
      if (user_wr_en) begin
        if (exp_q.size() == 0) check_val("wdata_unexpected", 64'(1), 64'(0));
        else if (user_wr_ready) begin
          check_val("wdata", 64'(user_wr_data), 64'(exp_q.pop_front()));
          check_val("wlast", 64'(user_wr_last), 64'(exp_last_q.pop_front()));
        end else begin
          check_val("wdata_hold", 64'(user_wr_data), 64'(exp_q[0]));
        end
      end
      if (user_cmd_ren) begin
        if (exp_rcmd_q.size() == 0) check_val("rcmd_unexpected", 64'(1), 64'(0));
        else check_val("rcmd", 64'(user_rd_cmd), 64'(exp_rcmd_q.pop_front()));
      end
`ifdef USER_TRAFFIC_RD_CHECK_EN
      if (rd_check_done) chk_done_seen++;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // stall_mask bit n forces ready low in cycle n after the trigger.
  task automatic do_write(input int len, input logic [1:0] mode, input int ready_pct,
                          input logic [31:0] stall_mask, input int intrude_cyc);
    int xfers;
    int done_cyc;
    bit seen;
    push_write(len, mode);
    @(posedge clk); #1;
    wr_trig = 1'b1; pkt_len = 12'(len); pat_mode = mode; user_wr_ready = 1'b1;
    xfers = 0; done_cyc = -1; seen = 0;
    for (int cyc = 1; cyc < 20000; cyc++) begin
      @(posedge clk); #1;
      wr_trig = 1'b0; rd_trig = 1'b0;
      user_wr_ready = ($urandom_range(0, 99) < ready_pct);
      if (cyc < 32 && stall_mask[cyc]) user_wr_ready = 1'b0;
      if (cyc == intrude_cyc) begin
        wr_trig = 1'b1; pkt_len = 12'd7; rd_trig = 1'b1;
        push_read(7);
      end
      @(negedge clk);
      if (cyc == 1) check_val("wr_busy", 64'(wr_busy), 64'(1));
      if (cyc == intrude_cyc + 1) check_val("rd_during_wr", 64'(user_cmd_ren), 64'(1));
      if (cyc == done_cyc) begin
        check_val("wr_done_time", 64'(wr_done), 64'(1));
        seen = 1;
        break;
      end else if (wr_done) begin
        check_val("wr_done_early", 64'(wr_done), 64'(0));
      end
      if (cyc >= 2 && xfers < len && user_wr_ready) begin
        xfers++;
        if (xfers == len) done_cyc = cyc + 1;
      end
    end
    if (!seen) check_val("wr_done_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    wr_trig = 1'b0; rd_trig = 1'b0; user_wr_ready = 1'b1;
    @(negedge clk);
    check_val("wr_idle_after", 64'(wr_busy), 64'(0));
  endtask

  task automatic do_read(input int len);
    push_read(len);
    @(posedge clk); #1;
    rd_trig = 1'b1; pkt_len = 12'(len);
    @(posedge clk); #1;
    rd_trig = 1'b0;
    @(negedge clk);
    check_val("rd_ren_next", 64'(user_cmd_ren), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rd_ren_one", 64'(user_cmd_ren), 64'(0));
    check_val("rd_cmd_zero", 64'(user_rd_cmd), 64'(0));
  endtask

  task automatic reset_model();
    exp_wcmd_q.delete(); exp_rcmd_q.delete(); exp_q.delete(); exp_last_q.delete();
    waddr_m = longint'(BASE); raddr_m = longint'(BASE); free_m = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; wr_trig = 1'b0; rd_trig = 1'b0; pkt_len = '0; pat_mode = '0;
    user_wr_ready = 1'b1;
`ifdef USER_TRAFFIC_RD_CHECK_EN
    user_rd_valid = 1'b0; user_rd_data = '0;
`endif
    reset_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_cmd_wen", 64'(user_cmd_wen), 64'(0));
    check_val("rst_wr_cmd", 64'(user_wr_cmd), 64'(0));
    check_val("rst_wr_en", 64'(user_wr_en), 64'(0));
    check_val("rst_wr_data", 64'(user_wr_data), 64'(0));
    check_val("rst_busy", 64'(wr_busy), 64'(0));
    check_val("rst_done", 64'(wr_done), 64'(0));
    check_val("rst_ren", 64'(user_cmd_ren), 64'(0));
    check_val("rst_rd_cmd", 64'(user_rd_cmd), 64'(0));

    // Basic 4-beat count packet, then a stalled 3-beat packet.
    do_write(4, 2'd0, 100, 32'h0, -1);
    do_write(3, 2'd0, 100, 32'h0000_0018, -1);
    // LFSR pattern repeats identically per packet; walking one; free count.
    do_write(2, 2'd2, 100, 32'h0, -1);
    do_write(2, 2'd2, 100, 32'h0, -1);
    do_write(20, 2'd3, 100, 32'h0, -1);
    do_write(5, 2'd1, 100, 32'h0, -1);
    do_write(3, 2'd1, 70, 32'h0, -1);
    // Zero-length request is ignored.
    @(posedge clk); #1; wr_trig = 1'b1; pkt_len = 12'd0;
    @(posedge clk); #1; wr_trig = 1'b0;
    @(negedge clk);
    check_val("len0_ignored", 64'(wr_busy), 64'(0));
    // Busy write trigger dropped while a simultaneous read goes through.
    do_write(6, 2'd0, 100, 32'h0, 2);
    do_read(5);
    // Maximum-length packets force the window wrap.
    for (int i = 0; i < 3; i++) do_write(4095, 2'(i), 100, 32'h0, -1);
    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      do_write($urandom_range(1, 40), 2'($urandom_range(0, 3)), 60, 32'h0, -1);
      if ($urandom_range(0, 1) == 1) do_read($urandom_range(1, 4095));
    end

    // Reset in the middle of a packet.
    push_write(8, 2'd0);
    @(posedge clk); #1; wr_trig = 1'b1; pkt_len = 12'd8; pat_mode = 2'd0;
    @(posedge clk); #1; wr_trig = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; user_wr_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0; user_wr_ready = 1'b1;
    @(negedge clk);
    check_val("midrst_busy", 64'(wr_busy), 64'(0));
    check_val("midrst_done", 64'(wr_done), 64'(0));
    check_val("midrst_wr_en", 64'(user_wr_en), 64'(0));
    reset_model();
    do_write(2, 2'd0, 100, 32'h0, -1);
    do_write(3, 2'd1, 100, 32'h0, -1);
    do_read(9);

`ifdef USER_TRAFFIC_RD_CHECK_EN
    do_write(4, 2'd0, 100, 32'h0, -1);
    do_read(4);
    begin
      int done_before;
      done_before = chk_done_seen;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        user_rd_valid = 1'b1;
        user_rd_data  = DW'(k) ^ ((k == 2) ? DW'(1) : DW'(0));
      end
      @(posedge clk); #1; user_rd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rd_err_cnt", 64'(rd_err_cnt), 64'(1));
      check_val("rd_check_done_once", 64'(chk_done_seen - done_before), 64'(1));
    end
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("wcmd_q_empty", 64'(exp_wcmd_q.size()), 64'(0));
    check_val("wdata_q_empty", 64'(exp_q.size()), 64'(0));
    check_val("rcmd_q_empty", 64'(exp_rcmd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/user_traffic_gen.md
Name: user_traffic_gen

Overview:
- Parametrised successor to the single-mode user write/read command generator.
- Drives user-side write commands with data beats, and read commands, into the AXI4 full master bridge.
- Adds runtime packet length, write backpressure, selectable data patterns and a wrapping address window.
- Sits between the test trigger logic and the user command/data FIFOs of the AXI master.

Parameters:
- AXI_ADDR_WIDTH, 32, byte address width.
- USER_DATA_WIDTH, 16, user data beat width in bits; multiple of 8, range 8..64.
- BASE_ADDR, 32'h0000_0000, first address of the traffic window.
- ADDR_SPAN, 32'h0010_0000, window size in bytes; power of two, at least the maximum packet in bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- wr_trig  in  1  one-cycle write request; honoured only when the write FSM is in IDLE.
- rd_trig  in  1  one-cycle read request; honoured only when user_cmd_ren is low.
- pkt_len  in  12  packet length in beats, 1..4095; sampled on an accepted trigger.
- pat_mode  in  2  data pattern; sampled on an accepted wr_trig.
- user_cmd_wen  out  1  write command strobe.
- user_wr_cmd  out  AXI_ADDR_WIDTH+12  {len[11:0], addr}; zero when user_cmd_wen is low.
- user_wr_en  out  1  write data valid.
- user_wr_ready  in  1  downstream accepts the beat (FIFO not full).
- user_wr_data  out  USER_DATA_WIDTH  write beat.
- user_wr_last  out  1  final beat of the packet; qualified by user_wr_en.
- wr_busy  out  1  write FSM is not in IDLE.
- wr_done  out  1  one-cycle pulse when a packet completes.
- user_cmd_ren  out  1  read command strobe.
- user_rd_cmd  out  AXI_ADDR_WIDTH+12  {len[11:0], addr}; zero when user_cmd_ren is low.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; waddr = raddr = BASE_ADDR; pattern counters 0; LFSR = 16'hACE1.
- Write FSM states: IDLE, WCMD, WDATA, WEND.
  - IDLE -> WCMD on wr_trig with pkt_len != 0. pkt_len and pat_mode are latched. pkt_len == 0 is ignored.
  - WCMD lasts exactly 1 cycle. user_cmd_wen = 1 and user_wr_cmd = {len, waddr}. Next state is WDATA.
  - WDATA: user_wr_en = 1. A beat transfers when user_wr_en & user_wr_ready. beat_cnt counts transferred beats.
  - user_wr_last = (beat_cnt == len-1).
  - Data is held stable while user_wr_ready is low.
  - WDATA -> WEND when the last beat transfers.
  - WEND lasts 1 cycle. wr_done = 1. waddr advances. Next state is IDLE.
  - wr_trig in any state other than IDLE is dropped.
- Write address step: len*(USER_DATA_WIDTH/8) bytes.
  - If (waddr + step) > BASE_ADDR+ADDR_SPAN-1 - (4095*bytes_per_beat), waddr wraps to BASE_ADDR.
  - The wrap check uses the worst-case next packet, so a packet never crosses the window end.
  - raddr uses the same step and wrap rule.
- Patterns, where k = beat index within the packet:
  - 0: k, restarting at 0 each packet.
  - 1: free-running counter continued across packets; never cleared except by reset.
  - 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, reseeded to 16'hACE1 at WCMD. The 16-bit value is replicated or truncated to USER_DATA_WIDTH. The LFSR steps on each transferred beat.
  - 3: walking one, 1 << (k mod USER_DATA_WIDTH).
- Counter arithmetic: all pattern counters wrap modulo 2^USER_DATA_WIDTH.
- Read path:
  - An accepted rd_trig registers user_cmd_ren = 1 on the next cycle for exactly 1 cycle.
  - During that cycle, user_rd_cmd = {pkt_len latched, raddr}.
  - raddr advances in the same cycle the command is presented.
  - Read is independent of write; wr_trig and rd_trig may be accepted in the same cycle.
- Reset mid-packet: the FSM returns to IDLE the next edge; no wr_done; addresses return to BASE_ADDR.

Optional Feature:
- Macro: USER_TRAFFIC_RD_CHECK_EN.
- Enabled, adds these ports:
  - in: user_rd_valid (1), user_rd_data (USER_DATA_WIDTH).
  - out: rd_err_cnt (16), rd_check_done (1).
- Enabled, behaviour:
  - A checker regenerates the pattern selected at the most recent accepted write, using beat index and LFSR state per read packet.
  - Each user_rd_valid beat is compared against the regenerated pattern.
  - rd_err_cnt increments on each mismatch and saturates at 16'hFFFF.
  - rd_check_done pulses when len beats have been received.
  - Pattern 1 is checked as restart-per-packet.
- Disabled: the ports are absent; no checker logic.

Test Plan:
- Reset, then wr_trig with pkt_len=4, mode 0, ready=1 -> WCMD cmd {12'h004, 0}; data 0,1,2,3; last on beat 3; wr_done 6 cycles after the trigger; waddr becomes 8 (16-bit data).
- pkt_len=3, ready low for 2 cycles on beat 1 -> data 1 held stable; total 3 transfers; wr_done delayed 2 cycles.
- Mode 2, pkt_len=2, 16-bit data -> beats ACE1, then the next LFSR value; second packet repeats the same values.
- Repeated 4095-beat writes with ADDR_SPAN=32'h4000 -> waddr wraps to BASE_ADDR; no command exceeds the window.
- wr_trig while busy, plus a simultaneous rd_trig -> write dropped; read cmd issued next cycle; raddr advances independently.
- With USER_TRAFFIC_RD_CHECK_EN, read back 4 beats with one corrupted -> rd_err_cnt=1 and rd_check_done pulses once.
